byte_2_word: RTL and testbench

BYTE_2_WORD -- requirements
Module: byte_2_word

---
 rtl/byte_2_word.sv | 87 ++++++++
 tb/tb_byte_2_word.sv | 136 +++++++++++++
 2 files changed

// File: rtl/byte_2_word.sv
// Pairs incoming bytes into 16-bit little-endian words, discarding a held low byte
// if its high byte does not arrive within TIMEOUT_CYCLES clocks.
module byte_2_word #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_dv,
  input  logic [7:0]  byteee,
  output logic        word_dv,
  output logic [15:0] word,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  // Value held during the last cycle in which a high byte is still accepted.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StIdle, StWaitHigh} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      low_q, low_d;
  logic [15:0]     word_q, word_d;
  logic            word_dv_q, word_dv_d;
  logic            timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    low_d         = low_q;
    word_d        = word_q;
    word_dv_d     = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (byte_dv) begin
          low_d   = byteee;
          cnt_d   = '0;
          state_d = StWaitHigh;
        end
      end
      StWaitHigh: begin
        // A byte in the final window cycle still wins over the timeout.
        if (byte_dv) begin
          word_d    = {byteee, low_q};
          word_dv_d = 1'b1;
          state_d   = StIdle;
        end else if (cnt_q == CntLast) begin
          low_d         = '0;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      low_q         <= '0;
      word_q        <= '0;
      word_dv_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      low_q         <= low_d;
      word_q        <= word_d;
      word_dv_q     <= word_dv_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign word        = word_q;
  assign word_dv     = word_dv_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q == StWaitHigh);

endmodule

// File: tb/tb_byte_2_word.sv
// Directed table-driven bench for byte_2_word; each vector is one clock of stimulus
// plus the outputs expected just after that clock edge.
module tb_byte_2_word;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_dv;
  logic [7:0]  byteee;
  logic        word_dv;
  logic [15:0] word;
  logic        busy;
  logic        timeout_err;

  byte_2_word #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_dv    (byte_dv),
    .byteee     (byteee),
    .word_dv    (word_dv),
    .word       (word),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic        dv;
    logic [7:0]  b;
    logic        exp_dv;
    logic [15:0] exp_word;
    logic        exp_busy;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input string tag, input logic r, input logic dv, input logic [7:0] b,
                     input logic edv, input logic [15:0] ew, input logic eb, input logic eto);
    vec_t v;
    v.tag = tag; v.rst = r; v.dv = dv; v.b = b;
    v.exp_dv = edv; v.exp_word = ew; v.exp_busy = eb; v.exp_to = eto;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic edv, input logic [15:0] ew,
                       input logic eb, input logic eto);
    n_vec++;
    if (word_dv !== edv || word !== ew || busy !== eb || timeout_err !== eto) begin
      n_fail++;
      $display("FAIL %s: got dv=%b word=%h busy=%b to=%b, need dv=%b word=%h busy=%b to=%b",
               tag, word_dv, word, busy, timeout_err, edv, ew, eb, eto);
    end
  endtask

  initial begin
    rst = 1'b1; byte_dv = 1'b0; byteee = 8'h00;

    add("reset0", 1, 0, 8'h00, 0, 16'h0000, 0, 0);
    add("reset1", 1, 0, 8'h00, 0, 16'h0000, 0, 0);
    add("idle",   0, 0, 8'hEE, 0, 16'h0000, 0, 0);
    // Back-to-back pair
    add("b2b_lo", 0, 1, 8'h34, 0, 16'h0000, 1, 0);
    add("b2b_hi", 0, 1, 8'h12, 1, 16'h1234, 0, 0);
    add("b2b_after", 0, 0, 8'h00, 0, 16'h1234, 0, 0);
    // Gapped pair, high byte 10 cycles after low
    add("gap_lo", 0, 1, 8'hCD, 0, 16'h1234, 1, 0);
    for (int i = 0; i < 9; i++) add("gap_wait", 0, 0, 8'h00, 0, 16'h1234, 1, 0);
    add("gap_hi", 0, 1, 8'hAB, 1, 16'hABCD, 0, 0);
    add("gap_after", 0, 0, 8'h00, 0, 16'hABCD, 0, 0);
    // Timeout: low at T, nothing through T+16, error seen in T+17
    add("to_lo", 0, 1, 8'h55, 0, 16'hABCD, 1, 0);
    for (int i = 0; i < 15; i++) add("to_wait", 0, 0, 8'h00, 0, 16'hABCD, 1, 0);
    add("to_err", 0, 0, 8'h00, 0, 16'hABCD, 0, 1);
    add("to_after", 0, 0, 8'h00, 0, 16'hABCD, 0, 0);
    add("to_next_lo", 0, 1, 8'h01, 0, 16'hABCD, 1, 0);
    add("to_next_hi", 0, 1, 8'h02, 1, 16'h0201, 0, 0);
    add("to_next_after", 0, 0, 8'h00, 0, 16'h0201, 0, 0);
    // Boundary: high byte exactly at T+16
    add("bnd_lo", 0, 1, 8'h11, 0, 16'h0201, 1, 0);
    for (int i = 0; i < 15; i++) add("bnd_wait", 0, 0, 8'h00, 0, 16'h0201, 1, 0);
    add("bnd_hi", 0, 1, 8'h22, 1, 16'h2211, 0, 0);
    add("bnd_after", 0, 0, 8'h00, 0, 16'h2211, 0, 0);
    // Streaming 0x01..0x08
    add("str1", 0, 1, 8'h01, 0, 16'h2211, 1, 0);
    add("str2", 0, 1, 8'h02, 1, 16'h0201, 0, 0);
    add("str3", 0, 1, 8'h03, 0, 16'h0201, 1, 0);
    add("str4", 0, 1, 8'h04, 1, 16'h0403, 0, 0);
    add("str5", 0, 1, 8'h05, 0, 16'h0403, 1, 0);
    add("str6", 0, 1, 8'h06, 1, 16'h0605, 0, 0);
    add("str7", 0, 1, 8'h07, 0, 16'h0605, 1, 0);
    add("str8", 0, 1, 8'h08, 1, 16'h0807, 0, 0);
    add("str_after", 0, 0, 8'h00, 0, 16'h0807, 0, 0);
    // Reset mid-pair; byte_dv during reset is ignored
    add("rst_lo", 0, 1, 8'h77, 0, 16'h0807, 1, 0);
    add("rst_on", 1, 1, 8'hFF, 0, 16'h0000, 0, 0);
    add("rst_hold", 1, 0, 8'h00, 0, 16'h0000, 0, 0);
    add("rst_lo2", 0, 1, 8'h88, 0, 16'h0000, 1, 0);
    add("rst_hi2", 0, 1, 8'h99, 1, 16'h9988, 0, 0);
    add("rst_after", 0, 0, 8'h00, 0, 16'h9988, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; byte_dv = vecs[i].dv; byteee = vecs[i].b;
      @(posedge clk);
      #1;
      check(vecs[i].tag, vecs[i].exp_dv, vecs[i].exp_word, vecs[i].exp_busy, vecs[i].exp_to);
    end

    // Asynchronous reset between clock edges, then next byte must be a low byte
    byte_dv = 1'b1; byteee = 8'h5A;
    @(posedge clk); #1;
    byte_dv = 1'b0;
    check("async_pre", 1'b0, 16'h9988, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 check("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    byte_dv = 1'b1; byteee = 8'hC3;
    @(posedge clk); #1;
    check("async_lo", 1'b0, 16'h0000, 1'b1, 1'b0);
    byteee = 8'h3C;
    @(posedge clk); #1;
    byte_dv = 1'b0;
    check("async_hi", 1'b1, 16'h3CC3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("async_after", 1'b0, 16'h3CC3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
